// File: rtl/timer_param.sv
// Parametrised stopwatch / interval timer: up or one-shot down counting behind a tick prescaler.
// Up runs either wrap (with a sticky overflow flag) or saturate; lap copies the live count into out.
module timer_param #(
   parameter int BIT_SZ   = 16,
   parameter int PRESCALE = 1,
   parameter int SATURATE = 0
) (
   input  logic              sysclk,
   input  logic              sreset,
   input  logic              tick,
   input  logic              start,
   input  logic              stop,
   input  logic              clear,
   input  logic              lap,
   input  logic              down,
   input  logic [BIT_SZ-1:0] load_val,
   output logic [BIT_SZ-1:0] count,
   output logic [BIT_SZ-1:0] out,
   output logic              running,
   output logic              tc,
   output logic              overflow
);

   localparam int              PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0]   PRE_LAST = PW'(PRESCALE - 1);
   localparam logic [BIT_SZ-1:0] ALL_ONES = '1;
   localparam logic [BIT_SZ-1:0] ONE      = BIT_SZ'(1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t            state;
   logic              dir_r;
   logic [PW-1:0]     prescaler;

   logic accept, zero_load, qualified, step, at_top, up_wrap, up_sat, down_end;

   // stop also blocks the step, so a stopped count holds exactly where it was
   assign accept    = (state == IDLE) && start && !stop;
   assign zero_load = accept && down && (load_val == '0);
   assign qualified = (state == RUN) && tick && !clear && !stop;
   assign step      = qualified && (prescaler == PRE_LAST);
   assign at_top    = (count == ALL_ONES);
   assign up_wrap   = step && !dir_r && at_top && (SATURATE == 0);
   assign up_sat    = step && !dir_r && at_top && (SATURATE != 0);
   assign down_end  = step && dir_r && (count == ONE);

   always_ff @(posedge sysclk or posedge sreset) begin
      if (sreset) begin
         state     <= IDLE;
         dir_r     <= 1'b0;
         count     <= '0;
         out       <= '0;
         prescaler <= '0;
         running   <= 1'b0;
         tc        <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         tc <= up_wrap || up_sat || down_end || zero_load;

         if (lap)
            out <= count;

         // A down start from zero terminates immediately and never enters RUN
         if (state == IDLE) begin
            if (accept) begin
               dir_r <= down;
               if (!zero_load) begin
                  state   <= RUN;
                  running <= 1'b1;
               end
            end
         end else if (stop || up_sat || down_end) begin
            state   <= IDLE;
            running <= 1'b0;
         end

         if (clear) begin
            count     <= '0;
            prescaler <= '0;
            overflow  <= 1'b0;
         end else if (accept && down) begin
            count     <= load_val;
            prescaler <= '0;
         end else if (qualified) begin
            if (step) begin
               prescaler <= '0;
               if (!dir_r) begin
                  if (!at_top) begin
                     count <= count + ONE;
                  end else if (SATURATE == 0) begin
                     count    <= '0;
                     overflow <= 1'b1;
                  end
               end else if (count != '0) begin
                  count <= count - ONE;
               end
            end else begin
               prescaler <= prescaler + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_timer_param.sv
// Bench for timer_param: three parameter sets share one stimulus stream, checked by a
// directed vector table, hand sequences for wrap/saturate/prescale/async reset, and a random run.
module tb_timer_param;

   logic        sysclk, sreset;
   logic        tick, start, stop, clear, lap, down;
   logic [15:0] load_val;
   logic [3:0]  load_small;

   logic [15:0] cnt_a, out_a;
   logic [3:0]  cnt_b, out_b, cnt_c, out_c;
   logic        run_a, tc_a, ovf_a, run_b, tc_b, ovf_b, run_c, tc_c, ovf_c;

   int total = 0;
   int bad   = 0;

   assign load_small = load_val[3:0];

   timer_param #(.BIT_SZ(16), .PRESCALE(1), .SATURATE(0)) dut_a (
      .sysclk(sysclk), .sreset(sreset), .tick(tick), .start(start), .stop(stop),
      .clear(clear), .lap(lap), .down(down), .load_val(load_val),
      .count(cnt_a), .out(out_a), .running(run_a), .tc(tc_a), .overflow(ovf_a));

   timer_param #(.BIT_SZ(4), .PRESCALE(3), .SATURATE(0)) dut_b (
      .sysclk(sysclk), .sreset(sreset), .tick(tick), .start(start), .stop(stop),
      .clear(clear), .lap(lap), .down(down), .load_val(load_small),
      .count(cnt_b), .out(out_b), .running(run_b), .tc(tc_b), .overflow(ovf_b));

   timer_param #(.BIT_SZ(4), .PRESCALE(1), .SATURATE(1)) dut_c (
      .sysclk(sysclk), .sreset(sreset), .tick(tick), .start(start), .stop(stop),
      .clear(clear), .lap(lap), .down(down), .load_val(load_small),
      .count(cnt_c), .out(out_c), .running(run_c), .tc(tc_c), .overflow(ovf_c));

   initial sysclk = 1'b0;
   always #5 sysclk = ~sysclk;

   // Reference model: a timer described by what it counts, not how it is built
   typedef struct {
      int cnt;
      int pre;
      int outv;
      bit run;
      bit dir;
      bit tcv;
      bit ovf;
   } mstate_t;

   function automatic mstate_t mreset();
      mstate_t m;
      m.cnt = 0; m.pre = 0; m.outv = 0;
      m.run = 0; m.dir = 0; m.tcv = 0; m.ovf = 0;
      return m;
   endfunction

   function automatic mstate_t model_next(mstate_t m, int bits, int ps, bit sat,
                                          bit st, bit sp, bit cl, bit lp, bit dn, bit tk, int ld);
      mstate_t n = m;
      int top = (1 << bits) - 1;
      int ldm = ld & top;
      n.tcv = 0;
      if (lp) n.outv = m.cnt;
      if (!m.run) begin
         if (st && !sp) begin
            n.dir = dn;
            if (dn) begin n.cnt = ldm; n.pre = 0; end
            if (dn && ldm == 0) n.tcv = 1;
            else n.run = 1;
         end
      end else if (sp) begin
         n.run = 0;
      end else if (tk && !cl) begin
         n.pre = m.pre + 1;
         if (n.pre == ps) begin
            n.pre = 0;
            if (!m.dir) begin
               if (m.cnt < top) n.cnt = m.cnt + 1;
               else begin
                  n.tcv = 1;
                  if (sat) n.run = 0;
                  else begin n.cnt = 0; n.ovf = 1; end
               end
            end else if (m.cnt > 0) begin
               n.cnt = m.cnt - 1;
               if (m.cnt == 1) begin n.tcv = 1; n.run = 0; end
            end
         end
      end
      if (cl) begin n.cnt = 0; n.pre = 0; n.ovf = 0; end
      return n;
   endfunction

   mstate_t ma, mb, mc;

   always @(posedge sysclk or posedge sreset) begin
      if (sreset) begin
         ma <= mreset();
         mb <= mreset();
         mc <= mreset();
      end else begin
         ma <= model_next(ma, 16, 1, 1'b0, start, stop, clear, lap, down, tick, int'(load_val));
         mb <= model_next(mb, 4, 3, 1'b0, start, stop, clear, lap, down, tick, int'(load_val));
         mc <= model_next(mc, 4, 1, 1'b1, start, stop, clear, lap, down, tick, int'(load_val));
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge sysclk);
      #1;
   endtask

   task automatic idle_inputs();
      start = 0; stop = 0; clear = 0; lap = 0; down = 0; tick = 0; load_val = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      sreset = 1'b1;
      cyc();
      cyc();
      sreset = 1'b0;
   endtask

   task automatic check_a(input string tag, input int e_cnt, input int e_out,
                          input bit e_run, input bit e_tc, input bit e_ovf);
      chk({tag, ".count"},    32'(cnt_a), 32'(e_cnt));
      chk({tag, ".out"},      32'(out_a), 32'(e_out));
      chk({tag, ".running"},  32'(run_a), 32'(e_run));
      chk({tag, ".tc"},       32'(tc_a),  32'(e_tc));
      chk({tag, ".overflow"}, 32'(ovf_a), 32'(e_ovf));
   endtask

   typedef struct {
      bit          st, sp, cl, lp, dn, tk;
      logic [15:0] ld;
      int          e_cnt, e_out;
      bit          e_run, e_tc, e_ovf;
   } vec_t;

   function automatic vec_t mk(bit st, bit sp, bit cl, bit lp, bit dn, bit tk, int ld,
                               int e_cnt, int e_out, bit e_run, bit e_tc, bit e_ovf);
      vec_t v;
      v.st = st; v.sp = sp; v.cl = cl; v.lp = lp; v.dn = dn; v.tk = tk; v.ld = 16'(ld);
      v.e_cnt = e_cnt; v.e_out = e_out; v.e_run = e_run; v.e_tc = e_tc; v.e_ovf = e_ovf;
      return v;
   endfunction

   vec_t vecs[$];

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      // st sp cl lp dn tk ld | count out run tc ovf  (expected after the edge)
      vecs.push_back(mk(1,0,0,0,0,1,0, 0,0,1,0,0));
      for (int i = 1; i <= 5; i++) vecs.push_back(mk(0,0,0,0,0,1,0, i,0,1,0,0));
      vecs.push_back(mk(0,1,0,0,0,1,0, 5,0,0,0,0));
      vecs.push_back(mk(0,0,0,0,0,1,0, 5,0,0,0,0));
      vecs.push_back(mk(1,0,0,0,0,1,0, 5,0,1,0,0));
      vecs.push_back(mk(0,0,0,0,0,1,0, 6,0,1,0,0));
      vecs.push_back(mk(0,0,0,0,0,1,0, 7,0,1,0,0));
      vecs.push_back(mk(0,0,1,0,0,1,0, 0,0,1,0,0));
      for (int i = 1; i <= 9; i++) vecs.push_back(mk(0,0,0,0,0,1,0, i,0,1,0,0));
      vecs.push_back(mk(0,0,0,1,0,1,0, 10,9,1,0,0));
      vecs.push_back(mk(0,0,0,0,0,1,0, 11,9,1,0,0));
      vecs.push_back(mk(0,1,0,0,0,0,0, 11,9,0,0,0));
      vecs.push_back(mk(1,1,0,0,0,1,0, 11,9,0,0,0));
      vecs.push_back(mk(1,0,0,0,1,1,3, 3,9,1,0,0));
      vecs.push_back(mk(0,0,0,0,0,1,0, 2,9,1,0,0));
      vecs.push_back(mk(0,0,0,0,0,1,0, 1,9,1,0,0));
      vecs.push_back(mk(0,0,0,0,0,1,0, 0,9,0,1,0));
      vecs.push_back(mk(0,0,0,0,0,1,0, 0,9,0,0,0));
      vecs.push_back(mk(1,0,0,0,1,1,0, 0,9,0,1,0));
      vecs.push_back(mk(0,0,0,0,0,1,0, 0,9,0,0,0));

      idle_inputs();
      sreset = 1'b1;
      #2;
      check_a("async_reset", 0, 0, 1'b0, 1'b0, 1'b0);
      do_reset();
      check_a("reset", 0, 0, 1'b0, 1'b0, 1'b0);

      foreach (vecs[i]) begin
         start = vecs[i].st; stop = vecs[i].sp; clear = vecs[i].cl; lap = vecs[i].lp;
         down = vecs[i].dn; tick = vecs[i].tk; load_val = vecs[i].ld;
         cyc();
         check_a($sformatf("vec%0d", i), vecs[i].e_cnt, vecs[i].e_out,
                 vecs[i].e_run, vecs[i].e_tc, vecs[i].e_ovf);
      end

      // Prescale by 3 and 4-bit wrap on dut_b
      do_reset();
      start = 1; cyc(); start = 0;
      chk("b_start.running", 32'(run_b), 32'd1);
      tick = 1;
      repeat (9) cyc();
      chk("b_pre9.count", 32'(cnt_b), 32'd3);
      for (int i = 0; i < 6; i++) begin
         tick = (i % 2 == 0);
         cyc();
      end
      chk("b_toggle.count", 32'(cnt_b), 32'd4);
      tick = 1;
      repeat (33) cyc();
      chk("b_top.count", 32'(cnt_b), 32'd15);
      chk("b_top.overflow", 32'(ovf_b), 32'd0);
      repeat (2) cyc();
      chk("b_hold.count", 32'(cnt_b), 32'd15);
      chk("b_hold.tc", 32'(tc_b), 32'd0);
      cyc();
      chk("b_wrap.count", 32'(cnt_b), 32'd0);
      chk("b_wrap.tc", 32'(tc_b), 32'd1);
      chk("b_wrap.overflow", 32'(ovf_b), 32'd1);
      chk("b_wrap.running", 32'(run_b), 32'd1);
      tick = 0;
      cyc();
      chk("b_after.tc", 32'(tc_b), 32'd0);
      chk("b_after.overflow", 32'(ovf_b), 32'd1);
      clear = 1; cyc(); clear = 0;
      chk("b_clear.overflow", 32'(ovf_b), 32'd0);
      chk("b_clear.count", 32'(cnt_b), 32'd0);

      // Saturation on dut_c
      do_reset();
      start = 1; tick = 1; cyc(); start = 0;
      chk("c_start.count", 32'(cnt_c), 32'd0);
      repeat (15) cyc();
      chk("c_top.count", 32'(cnt_c), 32'd15);
      chk("c_top.running", 32'(run_c), 32'd1);
      cyc();
      chk("c_sat.count", 32'(cnt_c), 32'd15);
      chk("c_sat.tc", 32'(tc_c), 32'd1);
      chk("c_sat.running", 32'(run_c), 32'd0);
      chk("c_sat.overflow", 32'(ovf_c), 32'd0);
      cyc();
      chk("c_after.tc", 32'(tc_c), 32'd0);
      chk("c_after.count", 32'(cnt_c), 32'd15);

      // Asynchronous reset in the middle of a run on dut_a
      do_reset();
      start = 1; tick = 1; cyc(); start = 0;
      repeat (11) cyc();
      lap = 1; cyc(); lap = 0;
      check_a("pre_areset", 12, 11, 1'b1, 1'b0, 1'b0);
      #3;
      sreset = 1'b1;
      #1;
      check_a("mid_areset", 0, 0, 1'b0, 1'b0, 1'b0);
      cyc();
      sreset = 1'b0;
      cyc();
      check_a("post_areset", 0, 0, 1'b0, 1'b0, 1'b0);

      // Random stimulus against the reference model on all three instances
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         start = ($urandom_range(0, 7) == 0);
         stop  = ($urandom_range(0, 15) == 0);
         clear = ($urandom_range(0, 31) == 0);
         lap   = ($urandom_range(0, 7) == 0);
         tick  = ($urandom_range(0, 3) != 0);
         down  = 1'($urandom_range(0, 1));
         load_val = ($urandom_range(0, 3) == 0) ? 16'($urandom()) : 16'($urandom_range(0, 6));
         cyc();
         chk("rnd_a.count", 32'(cnt_a), 32'(ma.cnt));
         chk("rnd_a.out", 32'(out_a), 32'(ma.outv));
         chk("rnd_a.running", 32'(run_a), 32'(ma.run));
         chk("rnd_a.tc", 32'(tc_a), 32'(ma.tcv));
         chk("rnd_a.overflow", 32'(ovf_a), 32'(ma.ovf));
         chk("rnd_b.count", 32'(cnt_b), 32'(mb.cnt));
         chk("rnd_b.out", 32'(out_b), 32'(mb.outv));
         chk("rnd_b.running", 32'(run_b), 32'(mb.run));
         chk("rnd_b.tc", 32'(tc_b), 32'(mb.tcv));
         chk("rnd_b.overflow", 32'(ovf_b), 32'(mb.ovf));
         chk("rnd_c.count", 32'(cnt_c), 32'(mc.cnt));
         chk("rnd_c.out", 32'(out_c), 32'(mc.outv));
         chk("rnd_c.running", 32'(run_c), 32'(mc.run));
         chk("rnd_c.tc", 32'(tc_c), 32'(mc.tcv));
         chk("rnd_c.overflow", 32'(ovf_c), 32'(mc.ovf));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
